traffic_ctrl_timed: RTL and testbench
=====================================

# traffic_ctrl_timed

Next-generation two-road intersection controller. The main/side light FSM is extended with an integrated parametrised phase timer, so no external TS/TL timer is needed. It also adds all-red clearance intervals, an extendable side green with a hard maximum, a latched pedestrian request with WALK output, and a night flashing mode. It drives the lamp outputs directly and keeps the one-cycle ST pulse on every state change for the existing monitor logic.

## Interface
- CNT_W, 16, width of the phase down-counter; every duration parameter must be ≤ 2^CNT_W.
- T_SHORT, 4, yellow duration in cycles (≥1).
- T_LONG, 16, minimum green duration in cycles (≥1).
- T_CLEAR, 2, all-red clearance duration in cycles (≥1).
- T_MAX, 32, maximum side-green duration in cycles (≥ T_LONG).
- FLASH_HALF, 8, half-period of the night-mode blink in cycles (≥1).

Ports:
- Clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- C  in  1  side-road car present (level).
- P  in  1  pedestrian request (pulse or level).
- night  in  1  night mode request (level).
- MR, MY, MG  out  1 each  main-road red/yellow/green lamps.
- SR, SY, SG  out  1 each  side-road red/yellow/green lamps.
- WALK  out  1  pedestrian walk lamp.
- ST  out  1  one-cycle pulse on every state change.
- state_o  out  3  current state code.

## Operation

States and lamps (unlisted lamps are 0):
- MAIN_GREEN: MG, SR.
- MAIN_YELLOW: MY, SR.
- CLEAR_TO_SIDE: MR, SR.
- SIDE_GREEN: MR, SG, and WALK if ped_served.
- SIDE_YELLOW: MR, SY.
- CLEAR_TO_MAIN: MR, SR.
- FLASH: MY = SR = flash_ph.

Phase timer:
- `tmr` loads duration−1 on entry to every state.
- It decrements each cycle and saturates at 0; expired = (tmr == 0).
- A state with duration N therefore lasts exactly N cycles when it exits on expiry.

Transitions (evaluated each rising edge; first matching rule wins):
- MAIN_GREEN (load T_LONG−1):
  - night → FLASH.
  - expired && (C || ped_pend) → MAIN_YELLOW.
  - Otherwise hold indefinitely; tmr stays at 0.
- MAIN_YELLOW (T_SHORT−1): expired → CLEAR_TO_SIDE.
- CLEAR_TO_SIDE (T_CLEAR−1): expired → SIDE_GREEN.
- SIDE_GREEN (T_MAX−1):
  - expired → SIDE_YELLOW.
  - !C && !ped_served && tmr ≤ T_MAX−T_LONG → SIDE_YELLOW. This is the minimum green, extended while C is high, up to T_MAX.
  - !C && ped_served && tmr ≤ T_MAX−T_LONG → SIDE_YELLOW. A served pedestrian gets exactly the minimum green.
- SIDE_YELLOW (T_SHORT−1): expired → CLEAR_TO_MAIN.
- CLEAR_TO_MAIN (T_CLEAR−1): expired → MAIN_GREEN.
- FLASH (load FLASH_HALF−1):
  - On expiry, toggle flash_ph and reload.
  - !night → CLEAR_TO_MAIN.
  - night is honoured only in MAIN_GREEN and FLASH. Elsewhere the normal cycle completes back to MAIN_GREEN first.

Pedestrian logic:
- ped_pend is set when P=1 in any state except FLASH.
- ped_pend is cleared on entry to SIDE_GREEN. On that same edge, ped_served is loaded with ped_pend.
- P asserted during SIDE_GREEN stays pending for the next cycle.
- ped_served clears on exit from SIDE_GREEN.
- P is ignored in FLASH.

## Timing

Reset (asynchronous, immediate):
- state = MAIN_GREEN, tmr = T_LONG−1.
- flash_ph = 1, ped_pend = 0, ped_served = 0, ST = 0.
- Outputs: MG = SR = 1, all other lamps 0, WALK = 0, state_o = MAIN_GREEN.
- Reset mid-phase abandons the phase with no yellow or clearance.

Registers and outputs:
- ST is registered: 1 for the cycle after each state-changing edge, else 0. It is never asserted by timer reloads inside FLASH.
- Lamps and WALK are a combinational decode of registered state, ped_served and flash_ph. No lamp is undefined in any cycle.

Simultaneous events:
- night beats C/ped in MAIN_GREEN.
- Expiry beats the !C early-exit in SIDE_GREEN; both give the same target, so this is not observable.

## Structure
- Package traffic_pkg holds:
  - the 3-bit state enum: MAIN_GREEN=0, MAIN_YELLOW=1, CLEAR_TO_SIDE=2, SIDE_GREEN=3, SIDE_YELLOW=4, CLEAR_TO_MAIN=5, FLASH=6;
  - a lamp-decode function from state to {MR,MY,MG,SR,SY,SG}.
- Sub-module phase_timer, parameterised by CNT_W:
  - inputs: load, load_val;
  - outputs: tmr, expired;
  - async active-low reset.

## Test plan
1. Release reset with C=P=night=0 for 200 cycles → state stays MAIN_GREEN; MG=SR=1 throughout; ST never pulses.
2. C=1 held from reset → state sequence and durations: MAIN_GREEN 16, MAIN_YELLOW 4, CLEAR_TO_SIDE 2, SIDE_GREEN 32 (max), SIDE_YELLOW 4, CLEAR_TO_MAIN 2, then MAIN_GREEN; 6 ST pulses.
3. C=1 until the 5th cycle of SIDE_GREEN, then 0 → SIDE_GREEN lasts exactly 16 cycles; WALK=0.
4. One-cycle P pulse at cycle 3 with C=0 → MAIN_GREEN exits after 16 cycles; SIDE_GREEN lasts 16 cycles with WALK=1 throughout; ped_pend is 0 afterwards; MAIN_GREEN then holds.
5. night=1 at MAIN_GREEN cycle 7 → FLASH next cycle; MY=SR alternate 8 cycles on / 8 off; all other lamps 0. night=0 → CLEAR_TO_MAIN for 2 cycles, then MAIN_GREEN.
6. reset_n low mid-SIDE_GREEN with WALK=1 → same cycle (asynchronous): MG=SR=1, WALK=0, ST=0. Restart behaves as scenario 1.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared state encoding and lamp decode for the timed two-road intersection controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN    = 3'd0,
        MAIN_YELLOW   = 3'd1,
        CLEAR_TO_SIDE = 3'd2,
        SIDE_GREEN    = 3'd3,
        SIDE_YELLOW   = 3'd4,
        CLEAR_TO_MAIN = 3'd5,
        FLASH         = 3'd6
    } state_t;

    // Returns {MR,MY,MG,SR,SY,SG}; the unused code falls back to all-red.
    function automatic logic [5:0] lamp_decode(input state_t s, input logic flash_ph);
        logic [5:0] l;
        case (s)
            MAIN_GREEN:    l = 6'b001_100;
            MAIN_YELLOW:   l = 6'b010_100;
            CLEAR_TO_SIDE: l = 6'b100_100;
            SIDE_GREEN:    l = 6'b100_001;
            SIDE_YELLOW:   l = 6'b100_010;
            CLEAR_TO_MAIN: l = 6'b100_100;
            FLASH:         l = {1'b0, flash_ph, 1'b0, flash_ph, 2'b00};
            default:       l = 6'b100_100;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating phase down-counter; load has priority over the decrement.
module phase_timer #(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] tmr,
    output logic             expired
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= RST_VAL;
        end else if (load) begin
            tmr <= load_val;
        end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end

    assign expired = (tmr == '0);

endmodule

// File: rtl/traffic_ctrl_timed.sv
// Two-road intersection controller with built-in phase timer, all-red clearance,
// extendable side green, latched pedestrian request and night flashing mode.
module traffic_ctrl_timed
    import traffic_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int T_SHORT    = 4,
    parameter int T_LONG     = 16,
    parameter int T_CLEAR    = 2,
    parameter int T_MAX      = 32,
    parameter int FLASH_HALF = 8
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       C,
    input  logic       P,
    input  logic       night,
    output logic       MR,
    output logic       MY,
    output logic       MG,
    output logic       SR,
    output logic       SY,
    output logic       SG,
    output logic       WALK,
    output logic       ST,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] L_SHORT = CNT_W'(T_SHORT - 1);
    localparam logic [CNT_W-1:0] L_LONG  = CNT_W'(T_LONG - 1);
    localparam logic [CNT_W-1:0] L_CLEAR = CNT_W'(T_CLEAR - 1);
    localparam logic [CNT_W-1:0] L_MAX   = CNT_W'(T_MAX - 1);
    localparam logic [CNT_W-1:0] L_FLASH = CNT_W'(FLASH_HALF - 1);
    // Side green has run at least T_LONG cycles once tmr falls to this value.
    localparam logic [CNT_W-1:0] EXT_LIM = CNT_W'(T_MAX - T_LONG);

    state_t           state;
    state_t           nxt;
    logic             reload;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] tmr;
    logic             expired;
    logic             flash_ph;
    logic             ped_pend;
    logic             ped_served;
    logic             st_q;

    always_comb begin
        nxt    = state;
        reload = 1'b0;
        case (state)
            MAIN_GREEN: begin
                if (night)                          nxt = FLASH;
                else if (expired && (C || ped_pend)) nxt = MAIN_YELLOW;
            end
            MAIN_YELLOW:   if (expired) nxt = CLEAR_TO_SIDE;
            CLEAR_TO_SIDE: if (expired) nxt = SIDE_GREEN;
            SIDE_GREEN: begin
                if (expired)                     nxt = SIDE_YELLOW;
                else if (!C && tmr <= EXT_LIM)   nxt = SIDE_YELLOW;
            end
            SIDE_YELLOW:   if (expired) nxt = CLEAR_TO_MAIN;
            CLEAR_TO_MAIN: if (expired) nxt = MAIN_GREEN;
            FLASH: begin
                // Leaving night mode takes priority over a blink reload.
                if (!night)       nxt    = CLEAR_TO_MAIN;
                else if (expired) reload = 1'b1;
            end
            default:              nxt = MAIN_GREEN;
        endcase
    end

    always_comb begin
        case (nxt)
            MAIN_GREEN:    load_val = L_LONG;
            MAIN_YELLOW:   load_val = L_SHORT;
            CLEAR_TO_SIDE: load_val = L_CLEAR;
            SIDE_GREEN:    load_val = L_MAX;
            SIDE_YELLOW:   load_val = L_SHORT;
            CLEAR_TO_MAIN: load_val = L_CLEAR;
            FLASH:         load_val = L_FLASH;
            default:       load_val = L_LONG;
        endcase
    end

    assign load = (nxt != state) || reload;

    phase_timer #(
        .CNT_W  (CNT_W),
        .RST_VAL(L_LONG)
    ) u_timer (
        .clk     (Clk),
        .rst_n   (reset_n),
        .load    (load),
        .load_val(load_val),
        .tmr     (tmr),
        .expired (expired)
    );

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= MAIN_GREEN;
            st_q       <= 1'b0;
            flash_ph   <= 1'b1;
            ped_pend   <= 1'b0;
            ped_served <= 1'b0;
        end else begin
            state <= nxt;
            st_q  <= (nxt != state);

            if (state != FLASH && nxt == FLASH) flash_ph <= 1'b1;
            else if (reload)                    flash_ph <= ~flash_ph;

            // A request arriving on the entry edge is kept for the next cycle.
            if (state != SIDE_GREEN && nxt == SIDE_GREEN) begin
                ped_served <= ped_pend;
                ped_pend   <= P;
            end else begin
                if (state == SIDE_GREEN && nxt != SIDE_GREEN) ped_served <= 1'b0;
                if (P && state != FLASH)                      ped_pend   <= 1'b1;
            end
        end
    end

    assign {MR, MY, MG, SR, SY, SG} = lamp_decode(state, flash_ph);
    assign WALK    = (state == SIDE_GREEN) && ped_served;
    assign ST      = st_q;
    assign state_o = state;

endmodule

// File: tb/tb_traffic_ctrl_timed.sv
// Directed testbench for traffic_ctrl_timed with default timing parameters.
module tb_traffic_ctrl_timed;

    logic       Clk;
    logic       reset_n;
    logic       C;
    logic       P;
    logic       night;
    logic       MR, MY, MG, SR, SY, SG;
    logic       WALK;
    logic       ST;
    logic [2:0] state_o;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int st_seen = 0;

    localparam logic [2:0] S_MG  = 3'd0;
    localparam logic [2:0] S_MY  = 3'd1;
    localparam logic [2:0] S_CTS = 3'd2;
    localparam logic [2:0] S_SG  = 3'd3;
    localparam logic [2:0] S_SY  = 3'd4;
    localparam logic [2:0] S_CTM = 3'd5;
    localparam logic [2:0] S_FL  = 3'd6;

    // Lamp vectors {MR,MY,MG,SR,SY,SG}
    localparam logic [5:0] LP_MG  = 6'b001_100;
    localparam logic [5:0] LP_MY  = 6'b010_100;
    localparam logic [5:0] LP_RED = 6'b100_100;
    localparam logic [5:0] LP_SG  = 6'b100_001;
    localparam logic [5:0] LP_SY  = 6'b100_010;
    localparam logic [5:0] LP_FON = 6'b010_100;

    wire [5:0] lamps = {MR, MY, MG, SR, SY, SG};

    traffic_ctrl_timed dut (
        .Clk    (Clk),
        .reset_n(reset_n),
        .C      (C),
        .P      (P),
        .night  (night),
        .MR     (MR),
        .MY     (MY),
        .MG     (MG),
        .SR     (SR),
        .SY     (SY),
        .SG     (SG),
        .WALK   (WALK),
        .ST     (ST),
        .state_o(state_o)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        if (ST === 1'b1) st_seen++;
    endtask

    // Leaves the bench just after an edge with reset released: this is cycle 1.
    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge Clk);
        #1;
        reset_n = 1'b1;
        st_seen = 0;
    endtask

    // Measures the remaining length of the current phase, starting at cycle 'start'.
    task automatic expect_phase(input string tag, input logic [2:0] s, input logic [5:0] lamp,
                                input int start, input int len, input logic [2:0] nxt,
                                output int walk_cnt);
        int n;
        n        = start;
        walk_cnt = int'(WALK);
        check({tag, "_state"}, 32'(state_o), 32'(s));
        check({tag, "_lamps"}, 32'(lamps), 32'(lamp));
        for (int k = 0; k < 200; k++) begin
            tick();
            if (state_o !== s) break;
            n++;
            walk_cnt += int'(WALK);
        end
        check({tag, "_len"}, 32'(n), 32'(len));
        check({tag, "_next"}, 32'(state_o), 32'(nxt));
        check({tag, "_st_pulse"}, 32'(ST), 32'd1);
    endtask

    task automatic check_idle(input string tag, input int n);
        int good;
        good = 0;
        for (int i = 0; i < n; i++) begin
            if (state_o === S_MG && lamps === LP_MG && WALK === 1'b0 && ST === 1'b0) good++;
            tick();
        end
        check(tag, 32'(good), 32'(n));
    endtask

    initial begin
        int w;
        int found;
        C       = 1'b0;
        P       = 1'b0;
        night   = 1'b0;
        reset_n = 1'b0;
        #2;
        check("rst_state", 32'(state_o), 32'(S_MG));
        check("rst_lamps", 32'(lamps), 32'(LP_MG));
        check("rst_walk_st", 32'({WALK, ST}), 32'd0);

        // 1: idle main green
        do_reset();
        check_idle("idle_200", 200);

        // 2: car held, side green runs to its maximum
        do_reset();
        C = 1'b1;
        expect_phase("c_mg",  S_MG,  LP_MG,  1, 16, S_MY,  w);
        expect_phase("c_my",  S_MY,  LP_MY,  1, 4,  S_CTS, w);
        expect_phase("c_cts", S_CTS, LP_RED, 1, 2,  S_SG,  w);
        expect_phase("c_sg",  S_SG,  LP_SG,  1, 32, S_SY,  w);
        check("c_sg_walk", 32'(w), 32'd0);
        expect_phase("c_sy",  S_SY,  LP_SY,  1, 4,  S_CTM, w);
        expect_phase("c_ctm", S_CTM, LP_RED, 1, 2,  S_MG,  w);
        check("c_st_count", 32'(st_seen), 32'd6);

        // 3: car leaves early in side green, minimum green applies
        do_reset();
        C = 1'b1;
        expect_phase("e_mg",  S_MG,  LP_MG,  1, 16, S_MY,  w);
        expect_phase("e_my",  S_MY,  LP_MY,  1, 4,  S_CTS, w);
        expect_phase("e_cts", S_CTS, LP_RED, 1, 2,  S_SG,  w);
        repeat (4) tick();
        C = 1'b0;
        expect_phase("e_sg",  S_SG,  LP_SG,  5, 16, S_SY,  w);
        check("e_sg_walk", 32'(w), 32'd0);

        // 4: single pedestrian pulse at cycle 3
        do_reset();
        tick();
        tick();
        P = 1'b1;
        tick();
        P = 1'b0;
        expect_phase("p_mg",  S_MG,  LP_MG,  4, 16, S_MY,  w);
        expect_phase("p_my",  S_MY,  LP_MY,  1, 4,  S_CTS, w);
        expect_phase("p_cts", S_CTS, LP_RED, 1, 2,  S_SG,  w);
        expect_phase("p_sg",  S_SG,  LP_SG,  1, 16, S_SY,  w);
        check("p_sg_walk", 32'(w), 32'd16);
        expect_phase("p_sy",  S_SY,  LP_SY,  1, 4,  S_CTM, w);
        check("p_sy_walk", 32'(WALK), 32'd0);
        expect_phase("p_ctm", S_CTM, LP_RED, 1, 2,  S_MG,  w);
        tick();
        check_idle("p_hold", 40);

        // 5: night flashing
        do_reset();
        repeat (6) tick();
        night = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            check("fl_state", 32'(state_o), 32'(S_FL));
            check("fl_lamps", 32'(lamps), ((i / 8) % 2 == 0) ? 32'(LP_FON) : 32'd0);
            check("fl_st", 32'(ST), (i == 0) ? 32'd1 : 32'd0);
            tick();
        end
        night = 1'b0;
        tick();
        expect_phase("fl_ctm", S_CTM, LP_RED, 1, 2, S_MG, w);

        // 6: asynchronous reset during a walk phase
        do_reset();
        P = 1'b1;
        tick();
        P = 1'b0;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            if (state_o === S_SG) begin
                found = 1;
                break;
            end
            tick();
        end
        check("ar_reach_sg", 32'(found), 32'd1);
        repeat (5) tick();
        check("ar_walk_before", 32'(WALK), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_state", 32'(state_o), 32'(S_MG));
        check("ar_lamps", 32'(lamps), 32'(LP_MG));
        check("ar_walk_st", 32'({WALK, ST}), 32'd0);
        do_reset();
        check_idle("ar_idle", 50);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
